fifo_drain_rr_arb: RTL and testbench

//  Round-robin drain scheduler that shares one downstream consumer between N_SRC

---
 rtl/fifo_drain_rr_arb.sv | 184 ++++++++++++++++++
 tb/tb_fifo_drain_rr_arb.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_drain_rr_arb.sv
`default_nettype none
// ============================================================================
// Module      : fifo_drain_rr_arb
// Description : Round-robin drain scheduler. Shares one downstream consumer
//               between N_SRC show-ahead FIFO read ports. Pops the granted
//               FIFO and forwards each word into a registered valid/ready
//               output stage, tagged with its source index. A grant is held
//               for up to MAX_BURST consecutive pops. An empty or disabled
//               FIFO is never popped.
// Ports       : clk, rstn        clock / synchronous active-low reset
//               cfg_en_i         per-source enable (0 = never granted)
//               fifo_valid_i     per-source non-empty flag
//               fifo_rd_data_i   show-ahead head words, source i at [i*DW +: DW]
//               fifo_pop_o       one-hot (or zero) pop strobe, combinational
//               out_valid_o / out_ready_i / out_data_o / out_src_o
//                                registered output stage
//               busy_o           high while a burst grant is held
// Revision    : 1.0 - initial release
// ============================================================================
module fifo_drain_rr_arb #(
    parameter  int N_SRC      = 4,
    parameter  int DATA_WIDTH = 32,
    parameter  int MAX_BURST  = 4,
    localparam int SRC_W      = $clog2(N_SRC),
    localparam int BCNT_W     = $clog2(MAX_BURST + 1)
) (
    input  logic                          clk,
    input  logic                          rstn,
    input  logic [N_SRC-1:0]              cfg_en_i,
    input  logic [N_SRC-1:0]              fifo_valid_i,
    input  logic [N_SRC*DATA_WIDTH-1:0]   fifo_rd_data_i,
    output logic [N_SRC-1:0]              fifo_pop_o,
    output logic                          out_valid_o,
    input  logic                          out_ready_i,
    output logic [DATA_WIDTH-1:0]         out_data_o,
    output logic [SRC_W-1:0]              out_src_o,
    output logic                          busy_o
);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;

    state_t                  state_q;
    logic [SRC_W-1:0]        rr_ptr_q;
    logic [SRC_W-1:0]        cur_src_q;
    logic [BCNT_W-1:0]       burst_cnt_q;
    logic [BCNT_W-1:0]       burst_cnt_d;
    logic                    out_valid_q;
    logic [DATA_WIDTH-1:0]   out_data_q;
    logic [SRC_W-1:0]        out_src_q;

    logic [N_SRC-1:0]        elig;
    logic                    load;
    logic                    win_found;
    logic [SRC_W-1:0]        win_idx;
    logic [SRC_W-1:0]        scan;
    logic                    pop_any;
    logic [SRC_W-1:0]        pop_idx;
    logic [DATA_WIDTH-1:0]   head [N_SRC];

    // Increment modulo N_SRC; handles non-power-of-two source counts.
    function automatic logic [SRC_W-1:0] inc_mod(input logic [SRC_W-1:0] i);
        if (i == SRC_W'(N_SRC - 1)) begin
            return '0;
        end
        return i + SRC_W'(1);
    endfunction

    genvar gi;
    generate
        for (gi = 0; gi < N_SRC; gi++) begin : g_head
            assign head[gi] = fifo_rd_data_i[gi*DATA_WIDTH +: DATA_WIDTH];
        end
    endgenerate

    assign elig        = fifo_valid_i & cfg_en_i;
    assign load        = ~out_valid_q | out_ready_i;
    assign burst_cnt_d = burst_cnt_q + BCNT_W'(1);

    // First eligible source found scanning upward from rr_ptr, wrapping.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        scan      = rr_ptr_q;
        for (int k = 0; k < N_SRC; k++) begin
            if (!win_found && elig[scan]) begin
                win_found = 1'b1;
                win_idx   = scan;
            end
            scan = inc_mod(scan);
        end
    end

    // Pop decision. Gated by rstn so a reset cycle never consumes a word.
    always_comb begin
        pop_any    = 1'b0;
        pop_idx    = win_idx;
        fifo_pop_o = '0;
        if (rstn && load) begin
            if (state_q == IDLE) begin
                pop_any = win_found;
            end else begin
                pop_any = elig[cur_src_q];
                pop_idx = cur_src_q;
            end
        end
        if (pop_any) begin
            fifo_pop_o[pop_idx] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q     <= IDLE;
            rr_ptr_q    <= '0;
            cur_src_q   <= '0;
            burst_cnt_q <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_src_q   <= '0;
        end else begin
            // Output stage: refill on a load cycle, otherwise hold for the sink.
            if (load) begin
                if (pop_any) begin
                    out_valid_q <= 1'b1;
                    out_data_q  <= head[pop_idx];
                    out_src_q   <= pop_idx;
                end else begin
                    out_valid_q <= 1'b0;
                end
            end

            case (state_q)
                IDLE: begin
                    if (pop_any) begin
                        cur_src_q   <= pop_idx;
                        burst_cnt_q <= BCNT_W'(1);
                        if (MAX_BURST == 1) begin
                            rr_ptr_q <= inc_mod(pop_idx);
                        end else begin
                            state_q <= BURST;
                        end
                    end
                end
                BURST: begin
                    if (load) begin
                        if (pop_any) begin
                            burst_cnt_q <= burst_cnt_d;
                            if (burst_cnt_d == BCNT_W'(MAX_BURST)) begin
                                rr_ptr_q <= inc_mod(cur_src_q);
                                state_q  <= IDLE;
                            end
                        end else begin
                            // Source ran dry or was disabled: give up the grant.
                            rr_ptr_q <= inc_mod(cur_src_q);
                            state_q  <= IDLE;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign out_valid_o = out_valid_q;
    assign out_data_o  = out_data_q;
    assign out_src_o   = out_src_q;
    assign busy_o      = (state_q == BURST);

`ifndef SYNTHESIS
    a_pop_onehot : assert property (@(posedge clk) disable iff (!rstn)
        $onehot0(fifo_pop_o));
    a_pop_elig : assert property (@(posedge clk) disable iff (!rstn)
        (fifo_pop_o & ~elig) == '0);
    a_pop_load : assert property (@(posedge clk) disable iff (!rstn)
        (fifo_pop_o != '0) |-> load);
    a_hold : assert property (@(posedge clk) disable iff (!rstn)
        (out_valid_q && !out_ready_i) |=> ($stable(out_data_q) && $stable(out_src_q)));
`endif

endmodule
`default_nettype wire

// File: tb/tb_fifo_drain_rr_arb.sv
`default_nettype none
// ============================================================================
// Module      : tb_fifo_drain_rr_arb
// Description : Self-checking bench for fifo_drain_rr_arb. Two instances run
//               side by side: A (N_SRC=4, MAX_BURST=4) and B (N_SRC=3,
//               MAX_BURST=1). Source FIFOs are queues inside the bench; a
//               cycle-level reference of the scheduling rules predicts pops
//               and output registers, and a per-source sequence scoreboard
//               checks that every delivered word arrives once and in order.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fifo_drain_rr_arb;

    localparam int DW = 32;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    // Instance A signals
    logic [3:0]   en_a, val_a, pop_a;
    logic [127:0] rd_a;
    logic         rdy_a, ov_a, busy_a;
    logic [31:0]  od_a;
    logic [1:0]   os_a;
    // Instance B signals
    logic [2:0]   en_b, val_b, pop_b;
    logic [95:0]  rd_b;
    logic         rdy_b, ov_b, busy_b;
    logic [31:0]  od_b;
    logic [1:0]   os_b;

    fifo_drain_rr_arb #(.N_SRC(4), .DATA_WIDTH(DW), .MAX_BURST(4)) u_dut_a (
        .clk(clk), .rstn(rstn), .cfg_en_i(en_a), .fifo_valid_i(val_a),
        .fifo_rd_data_i(rd_a), .fifo_pop_o(pop_a), .out_valid_o(ov_a),
        .out_ready_i(rdy_a), .out_data_o(od_a), .out_src_o(os_a), .busy_o(busy_a));

    fifo_drain_rr_arb #(.N_SRC(3), .DATA_WIDTH(DW), .MAX_BURST(1)) u_dut_b (
        .clk(clk), .rstn(rstn), .cfg_en_i(en_b), .fifo_valid_i(val_b),
        .fifo_rd_data_i(rd_b), .fifo_pop_o(pop_b), .out_valid_o(ov_b),
        .out_ready_i(rdy_b), .out_data_o(od_b), .out_src_o(os_b), .busy_o(busy_b));

    // Uniform views of both instances
    logic [3:0]  dpop [2];
    logic        dov [2];
    logic [31:0] dod [2];
    logic [1:0]  dos [2];
    logic        dbusy [2];
    always_comb begin
        dpop[0] = pop_a;          dpop[1] = {1'b0, pop_b};
        dov[0]  = ov_a;           dov[1]  = ov_b;
        dod[0]  = od_a;           dod[1]  = od_b;
        dos[0]  = os_a;           dos[1]  = os_b;
        dbusy[0] = busy_a;        dbusy[1] = busy_b;
    end

    int NS [2] = '{4, 3};
    int MB [2] = '{4, 1};

    // Bench-side FIFOs and stimulus
    logic [31:0] q [2][4][$];
    int          seq [2][4];
    int          nxt [2][4];
    logic [3:0]  en [2];
    logic        rdy [2];
    int          acc [2][$];
    logic [3:0]  last_pop [2];
    int          npop [2];

    // Reference state
    int          owner [2];
    int          cnt [2];
    int          ptr [2];
    logic        ev [2];
    logic [31:0] ed [2];
    int          es [2];

    int n_cmp = 0;
    int n_err = 0;

    function automatic logic [31:0] mk(int d, int s, int n);
        return {4'(d), 4'(s), 24'(n)};
    endfunction

    function automatic bit elig(int d, int i);
        return (i < NS[d]) && en[d][i] && (q[d][i].size() > 0);
    endfunction

    task automatic chk(int d, string tag, logic [63:0] o, logic [63:0] e);
        n_cmp++;
        assert (o === e) else begin
            n_err++;
            $error("FAIL d%0d %s observed=%0h expected=%0h", d, tag, o, e);
        end
    endtask

    task automatic push(int d, int s);
        q[d][s].push_back(mk(d, s, seq[d][s]));
        seq[d][s]++;
    endtask

    task automatic fill_all(int d, int n);
        for (int s = 0; s < NS[d]; s++)
            while (q[d][s].size() < n) push(d, s);
    endtask

    task automatic drive();
        logic [3:0]   vl [2];
        logic [127:0] rv [2];
        for (int d = 0; d < 2; d++) begin
            vl[d] = '0;
            rv[d] = '0;
            for (int s = 0; s < NS[d]; s++) begin
                if (q[d][s].size() > 0) begin
                    vl[d][s] = 1'b1;
                    rv[d][s*DW +: DW] = q[d][s][0];
                end
            end
        end
        en_a = en[0];  val_a = vl[0];       rd_a = rv[0];       rdy_a = rdy[0];
        en_b = en[1][2:0]; val_b = vl[1][2:0]; rd_b = rv[1][95:0]; rdy_b = rdy[1];
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            owner[d] = -1; cnt[d] = 0; ptr[d] = 0;
            ev[d] = 1'b0; ed[d] = '0; es[d] = 0;
            // A word held in the output stage is lost; resume at each queue head.
            for (int s = 0; s < 4; s++)
                nxt[d][s] = (q[d][s].size() > 0) ? int'(q[d][s][0][23:0]) : seq[d][s];
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rstn = 1'b0;
        drive();
        #1;
        for (int d = 0; d < 2; d++) chk(d, "pop_in_reset", 64'(dpop[d]), 64'd0);
        model_reset();
        @(posedge clk);
        #1;
        rstn = 1'b1;
    endtask

    // One clock cycle: drive, compare against the reference, advance it.
    task automatic step();
        int p, s, idx;
        bit ld;
        logic [3:0] ev_vec;
        @(negedge clk);
        drive();
        #1;
        for (int d = 0; d < 2; d++) begin
            chk(d, "out_valid", 64'(dov[d]), 64'(ev[d]));
            chk(d, "out_data",  64'(dod[d]), 64'(ed[d]));
            chk(d, "out_src",   64'(dos[d]), 64'(es[d]));
            chk(d, "busy",      64'(dbusy[d]), 64'(owner[d] >= 0));
            if (dov[d] && rdy[d]) begin
                s = int'(dos[d]);
                chk(d, "order", 64'(dod[d]), 64'(mk(d, s, nxt[d][s])));
                nxt[d][s]++;
                acc[d].push_back(s);
            end
            ld = !ev[d] || rdy[d];
            p = -1;
            if (ld) begin
                if (owner[d] < 0) begin
                    for (int k = 0; k < NS[d]; k++) begin
                        idx = (ptr[d] + k) % NS[d];
                        if (p < 0 && elig(d, idx)) p = idx;
                    end
                end else if (elig(d, owner[d])) begin
                    p = owner[d];
                end
            end
            ev_vec = (p >= 0) ? 4'(1 << p) : 4'd0;
            chk(d, "fifo_pop", 64'(dpop[d]), 64'(ev_vec));
            last_pop[d] = dpop[d];
            if (dpop[d] != 0) npop[d]++;
            if (ld) begin
                if (p >= 0) begin
                    ev[d] = 1'b1; ed[d] = q[d][p].pop_front(); es[d] = p;
                end else begin
                    ev[d] = 1'b0;
                end
            end
            if (owner[d] < 0) begin
                if (p >= 0) begin
                    if (MB[d] == 1) ptr[d] = (p + 1) % NS[d];
                    else begin owner[d] = p; cnt[d] = 1; end
                end
            end else if (ld) begin
                if (p >= 0) cnt[d]++;
                if (p < 0 || cnt[d] == MB[d]) begin
                    ptr[d] = (owner[d] + 1) % NS[d];
                    owner[d] = -1;
                end
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "bench timed out");
    end

    initial begin
        int n, ok;
        for (int d = 0; d < 2; d++) begin
            en[d] = '0; rdy[d] = 1'b0; npop[d] = 0; last_pop[d] = '0;
            for (int s = 0; s < 4; s++) begin seq[d][s] = 0; nxt[d][s] = 0; end
        end
        drive();
        do_reset();

        // Reset state followed by full-load round robin
        en[0] = 4'hF; en[1] = 4'h7; rdy[0] = 1'b1; rdy[1] = 1'b1;
        fill_all(0, 8); fill_all(1, 8);
        acc[0].delete(); acc[1].delete();
        repeat (34) step();
        chk(0, "t1_count", 64'(acc[0].size() >= 16), 64'd1);
        chk(1, "t6_count", 64'(acc[1].size() >= 6), 64'd1);
        for (int i = 0; i < 16 && i < acc[0].size(); i++)
            chk(0, $sformatf("t1_src[%0d]", i), 64'(acc[0][i]), 64'((i / 4) % 4));
        for (int i = 0; i < 6 && i < acc[1].size(); i++)
            chk(1, $sformatf("t6_src[%0d]", i), 64'(acc[1][i]), 64'(i % 3));
        repeat (10) step();

        // Lone source runs dry; next grant scans from the following index
        acc[0].delete();
        push(0, 2); push(0, 2);
        repeat (6) step();
        push(0, 0); push(0, 3);
        repeat (6) step();
        chk(0, "t2_count", 64'(acc[0].size()), 64'd4);
        if (acc[0].size() == 4) begin
            chk(0, "t2_a", 64'(acc[0][0]), 64'd2);
            chk(0, "t2_b", 64'(acc[0][1]), 64'd2);
            chk(0, "t2_c", 64'(acc[0][2]), 64'd3);
            chk(0, "t2_d", 64'(acc[0][3]), 64'd0);
        end

        // Back-pressure mid-burst
        fill_all(0, 8);
        repeat (3) step();
        rdy[0] = 1'b0;
        n = npop[0];
        repeat (5) step();
        chk(0, "t3_no_pop_stalled", 64'(npop[0] - n), 64'd0);
        rdy[0] = 1'b1;
        repeat (30) step();

        // Disabled source never popped; clearing enable ends a burst
        en[0] = 4'b1011;
        n = 0;
        for (int i = 0; i < 40; i++) begin
            fill_all(0, 8);
            step();
            if (last_pop[0][2]) n++;
        end
        chk(0, "t4_src2_pops", 64'(n), 64'd0);
        ok = 0;
        for (int i = 0; i < 20 && !ok; i++) begin
            fill_all(0, 8);
            step();
            if (owner[0] == 1 && dbusy[0]) ok = 1;
        end
        chk(0, "t4_src1_burst_seen", 64'(ok), 64'd1);
        en[0] = 4'b1001;
        step();
        chk(0, "t4_end_no_pop", 64'(last_pop[0]), 64'd0);
        step();
        chk(0, "t4_src3_granted", 64'(last_pop[0]), 64'b1000);

        // Reset mid-burst; first grant goes to lowest eligible index
        en[0] = 4'hF;
        ok = 0;
        for (int i = 0; i < 20 && !ok; i++) begin
            fill_all(0, 8); fill_all(1, 8);
            step();
            if (owner[0] >= 0 && cnt[0] >= 2) ok = 1;
        end
        chk(0, "t5_burst_seen", 64'(ok), 64'd1);
        do_reset();
        en[0] = 4'b1110; en[1] = 4'b0110;
        step();
        chk(0, "t5_first_grant", 64'(last_pop[0]), 64'b0010);
        chk(1, "t5_first_grant", 64'(last_pop[1]), 64'b0010);

        // Randomized traffic, enables and back-pressure
        for (int i = 0; i < 400; i++) begin
            for (int d = 0; d < 2; d++) begin
                en[d]  = 4'($urandom_range(0, 15));
                rdy[d] = ($urandom_range(0, 9) < 7);
                if ($urandom_range(0, 2) != 0) begin
                    n = $urandom_range(0, NS[d] - 1);
                    if (q[d][n].size() < 8) push(d, n);
                end
            end
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
